// File: rtl/coarse_ctrl.sv
// -----------------------------------------------------------------------------
// coarse_ctrl
//
// Sequences one coarse time measurement. A start hit enables an external
// coarse counter. A stop hit, or the run timeout, freezes the counter and
// strobes its store register. The stored count is then presented on oData
// with a valid/ready handshake.
//
// Parameters
//   C_DIG      width of the coarse count
//   C_TIMEOUT  maximum RUN length in clk cycles (1 .. 2**C_DIG-1)
//
// Ports
//   clk           system clock, all logic on rising edge
//   iRst          synchronous active-high reset
//   iStart        start hit, honoured only in IDLE
//   iStop         stop hit, honoured only in RUN
//   oCoarseRst    coarse counter clear (high in IDLE)
//   oCoarseCE     coarse counter enable (high in RUN)
//   oCoarseStore  coarse counter store strobe (high in CAPT)
//   iCoarse       stored coarse count, valid the cycle after the store strobe
//   oData         {overflow flag, coarse count}
//   oValid        oData valid
//   iReady        consumer accepts oData
//   oBusy         high in every state except IDLE
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | counter held in reset, waiting for a start hit
// RUN   | counter enabled, waiting for stop hit or timeout
// CAPT  | counter frozen, store strobe issued
// WAIT  | stored count settles on iCoarse, latched into oData
// OUT   | oData presented with oValid until iReady
// -----------------------------------------------------------------------------
module coarse_ctrl #(
  parameter int C_DIG     = 10,
  parameter int C_TIMEOUT = 2**C_DIG - 1
) (
  input  logic             clk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iStop,
  output logic             oCoarseRst,
  output logic             oCoarseCE,
  output logic             oCoarseStore,
  input  logic [C_DIG-1:0] iCoarse,
  output logic [C_DIG:0]   oData,
  output logic             oValid,
  input  logic             iReady,
  output logic             oBusy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_CAPT = 3'd2,
    S_WAIT = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  // The run length is timed with a down-counter loaded on entry to RUN.
  // It holds C_TIMEOUT-k during RUN cycle k, so reaching zero marks the
  // C_TIMEOUT-th RUN cycle and the run can never exceed that length.
  localparam logic [C_DIG-1:0] TC_LOAD = C_DIG'(C_TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [C_DIG-1:0] remain;
  logic [C_DIG-1:0] remain_nxt;
  logic             ovf;
  logic             ovf_nxt;
  logic [C_DIG:0]   data_nxt;
  logic             run_tc;

  assign run_tc = (remain == '0);

  always_ff @(posedge clk) begin
    if (iRst) begin
      state  <= S_IDLE;
      remain <= '0;
      ovf    <= 1'b0;
      oData  <= '0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
      ovf    <= ovf_nxt;
      oData  <= data_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    remain_nxt   = remain;
    ovf_nxt      = ovf;
    data_nxt     = oData;
    oCoarseRst   = 1'b0;
    oCoarseCE    = 1'b0;
    oCoarseStore = 1'b0;
    oValid       = 1'b0;
    oBusy        = 1'b1;

    case (state)
      S_IDLE: begin
        oCoarseRst = 1'b1;
        oBusy      = 1'b0;
        remain_nxt = '0;
        // A stop arriving together with the start is deliberately dropped:
        // the counter has not run yet, so there is nothing to measure.
        if (iStart) begin
          state_nxt  = S_RUN;
          remain_nxt = TC_LOAD;
          ovf_nxt    = 1'b0;
        end
      end

      S_RUN: begin
        oCoarseCE = 1'b1;
        // A real stop on the timeout cycle wins, so the flag stays clear.
        if (iStop) begin
          state_nxt = S_CAPT;
          ovf_nxt   = 1'b0;
        end else if (run_tc) begin
          state_nxt = S_CAPT;
          ovf_nxt   = 1'b1;
        end else begin
          remain_nxt = remain - 1'b1;
        end
      end

      S_CAPT: begin
        oCoarseStore = 1'b1;
        state_nxt    = S_WAIT;
      end

      S_WAIT: begin
        data_nxt  = {ovf, iCoarse};
        state_nxt = S_OUT;
      end

      S_OUT: begin
        oValid = 1'b1;
        if (iReady) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
